// File: rtl/seg_display_driver_pkg.sv
// seg_display_driver_pkg: shared FSM states, digit count and 7-segment glyph lookup
package seg_display_driver_pkg;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  localparam int NUM_DIGITS = 3;
  localparam logic [16*7-1:0] GLYPHS = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  function automatic logic [6:0] glyph(input logic [3:0] d);
    return GLYPHS[d*7 +: 7];
  endfunction
endpackage

// File: rtl/seg_display_driver_if.sv
// seg_display_driver_if: valid/ready result-word handshake into the display driver
interface seg_display_driver_if;
  logic [7:0] value;
  logic       value_valid;
  logic       dec_mode;
  logic       ready;
  modport master (output value, value_valid, dec_mode, input ready);
  modport slave  (input value, value_valid, dec_mode, output ready);
endinterface

// File: rtl/seg_display_driver_bin2bcd_serial.sv
// bin2bcd_serial: 8-step serial double-dabble; done flags the edge that performs the final step
module bin2bcd_serial (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);
  logic [7:0]  sr;
  logic [2:0]  cnt;
  logic        busy;
  logic [11:0] adj;
  always_comb begin
    adj = bcd;
    for (int n = 0; n < 3; n++)
      adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
  end
  assign done = busy && cnt == 3'd7;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sr   <= bin;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      {bcd, sr} <= {adj[10:0], sr, 1'b0};
      cnt       <= cnt + 3'd1;
      busy      <= !done;
    end
  end
endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: accepts a result word, converts to hex/decimal digits and
// scans them onto a shared 7-segment bus with one-hot digit enables
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  seg_display_driver_if.slave   bus,
  input  logic                  lzb,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en
);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
  state_t      state, state_n;
  logic [7:0]  val_q;
  logic        dec_q;
  logic [11:0] sh;
  logic        sh_dec;
  logic [1:0]  scan;
  logic [RW-1:0] rcnt;
  logic [11:0] bcd;
  logic        done;
  logic        accept;
  logic [3:0]  digit;
  logic        blank;
  assign bus.ready = state == IDLE;
  assign accept    = bus.ready && bus.value_valid;
  bin2bcd_serial u_conv (
    .clock (clock),
    .reset (reset),
    .start (accept),
    .bin   (bus.value),
    .bcd   (bcd),
    .done  (done)
  );
  always_comb begin
    state_n = (state == IDLE && accept) ? CONV   :
              (state == CONV && done)   ? COMMIT :
              (state == COMMIT)         ? IDLE   : state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val_q  <= '0;
      dec_q  <= 1'b0;
      sh     <= '0;
      sh_dec <= 1'b0;
    end else begin
      if (accept) begin
        val_q <= bus.value;
        dec_q <= bus.dec_mode;
      end
      if (state == COMMIT) begin
        sh     <= dec_q ? bcd : {4'h0, val_q};
        sh_dec <= dec_q;
      end
    end
  end
  // hex shadow keeps hundreds at zero, so digit1 blanking reduces to the dec rule
  assign digit = scan == 2'd0 ? sh[3:0] : scan == 2'd1 ? sh[7:4] : sh[11:8];
  assign blank = scan == 2'd2 ? (!sh_dec || (lzb && sh[11:8] == 4'h0)) :
                 scan == 2'd1 ? (lzb && sh[7:4] == 4'h0 && sh[11:8] == 4'h0) : 1'b0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rcnt   <= '0;
      scan   <= '0;
      seg    <= '0;
      dig_en <= '0;
    end else begin
      rcnt   <= rcnt == RMAX ? '0 : rcnt + 1'b1;
      scan   <= rcnt != RMAX ? scan : scan == 2'd2 ? 2'd0 : scan + 2'd1;
      seg    <= blank ? 7'h00 : glyph(digit);
      dig_en <= 3'b001 << scan;
    end
  end
endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: directed scoreboard bench for the 7-segment display driver
module tb_seg_display_driver;
  typedef struct {logic [7:0] v; bit dec;} item_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic lzb = 1'b0;
  logic [6:0] seg;
  logic [2:0] dig_en;
  int total = 0;
  int bad = 0;
  item_t sbq[$];
  item_t cur;
  logic [6:0] gt[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  seg_display_driver_if bus ();
  seg_display_driver #(.REFRESH_DIV(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .lzb    (lzb),
    .seg    (seg),
    .dig_en (dig_en)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask
  function automatic logic [20:0] model(input logic [7:0] v, input bit dec, input logic lz);
    int h, t, u;
    logic [6:0] d2, d1, d0;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (dec) begin
      d2 = (lz && h == 0) ? 7'h00 : gt[h];
      d1 = (lz && h == 0 && t == 0) ? 7'h00 : gt[t];
      d0 = gt[u];
    end else begin
      d2 = 7'h00;
      d1 = (lz && v[7:4] == 4'h0) ? 7'h00 : gt[v[7:4]];
      d0 = gt[v[3:0]];
    end
    return {d2, d1, d0};
  endfunction
  task automatic verify(input string tag, input item_t it);
    logic [6:0] got[3];
    logic [20:0] e;
    got = '{7'bx, 7'bx, 7'bx};
    repeat (2) tick;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk({tag, "_onehot"}, 32'($onehot(dig_en)), 1);
      if (dig_en == 3'b001) got[0] = seg;
      if (dig_en == 3'b010) got[1] = seg;
      if (dig_en == 3'b100) got[2] = seg;
    end
    e = model(it.v, it.dec, lzb);
    chk({tag, "_d0"}, 32'(got[0]), 32'(e[6:0]));
    chk({tag, "_d1"}, 32'(got[1]), 32'(e[13:7]));
    chk({tag, "_d2"}, 32'(got[2]), 32'(e[20:14]));
  endtask
  task automatic accept(input logic [7:0] v, input bit dec, input int mode);
    int n = 0;
    int low = 0;
    while (!bus.ready && n < 50) begin
      tick;
      n++;
    end
    chk("acc_ready", 32'(bus.ready), 1);
    bus.value = v;
    bus.dec_mode = dec;
    bus.value_valid = 1'b1;
    tick;
    bus.value_valid = 1'b0;
    bus.dec_mode = !dec;
    for (int i = 0; i < 9; i++) begin
      if (mode == 2 && i == 4) begin
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.ready), 1);
        chk("abort_dig_en", 32'(dig_en), 0);
        chk("abort_seg", 32'(seg), 0);
        tick;
        reset = 1'b0;
        tick;
        chk("abort_scan_dig", 32'(dig_en), 32'h1);
        chk("abort_scan_seg", 32'(seg), 32'h3F);
        sbq.push_back(item_t'{v: 8'd0, dec: 1'b0});
        return;
      end
      low += bus.ready ? 0 : 1;
      bus.value = (mode == 1 && (i == 2 || i == 7)) ? 8'd42 : v;
      bus.value_valid = mode == 1 && (i == 2 || i == 7);
      tick;
    end
    bus.value_valid = 1'b0;
    chk("ready_low_cycles", 32'(low), 9);
    chk("ready_back", 32'(bus.ready), 1);
    sbq.push_back(item_t'{v: v, dec: dec});
  endtask
  initial begin
    bus.value = '0;
    bus.value_valid = 1'b0;
    bus.dec_mode = 1'b0;
    repeat (3) tick;
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_seg", 32'(seg), 0);
    chk("rst_dig_en", 32'(dig_en), 0);
    reset = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick;
      chk("scan_dig_en", 32'(dig_en), 32'(3'b001 << (((j - 1) / 4) % 3)));
      chk("scan_seg", 32'(seg), j <= 8 ? 32'h3F : 32'h00);
      chk("scan_ready", 32'(bus.ready), 1);
    end
    accept(8'hA7, 1'b0, 0);
    verify("hex_a7", sbq.pop_front());
    accept(8'd255, 1'b1, 0);
    verify("dec_255", sbq.pop_front());
    lzb = 1'b1;
    accept(8'd7, 1'b1, 0);
    cur = sbq.pop_front();
    verify("dec_7_lzb", cur);
    lzb = 1'b0;
    verify("dec_7_nolzb", cur);
    accept(8'd100, 1'b1, 1);
    verify("dec_100_busy", sbq.pop_front());
    lzb = 1'b1;
    accept(8'h05, 1'b0, 0);
    verify("hex_05_lzb", sbq.pop_front());
    lzb = 1'b0;
    accept(8'd200, 1'b1, 2);
    verify("abort_200", sbq.pop_front());
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
